mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline. Sits between the EX/MEM register and the MEM/WB register (`mem_wb`). Decodes load/store instructions and runs a req/ack transaction on the data bus, holding the pipeline while the access is in flight. It then presents load results (byte/half extracted, sign/zero extended) and store records to `mem_wb`. Non-memory instructions pass through combinationally with no stall.

---
 rtl/mem_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Load/store stage: decodes mem ops and runs a req/ack data-bus transaction toward mem_wb.
// Latency: 0 cycles for non-mem/misaligned ops, 2+ack-delay for bus ops; holds the pipeline until DONE.
module mem_stage #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk_100MHz,
    input  logic        arst,
    input  logic [31:0] INST_i,
    input  logic        reg_wena_i,
    input  logic [31:0] reg_wdata_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_sdata_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [31:0] dbus_wdata_o,
    output logic [3:0]  dbus_be_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        hold_req_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic [31:0] INST_o,
    output logic        mem_rena_o,
    output logic [31:0] mem_rdata_o,
    output logic [31:0] mem_raddr_o,
    output logic        reg_wena_o,
    output logic [31:0] reg_wdata_o,
    output logic [4:0]  reg_waddr_o,
    output logic        mem_wena_o,
    output logic [31:0] mem_waddr_o,
    output logic [31:0] mem_wdata_o
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        dbus_req_q, dbus_req_d;
    logic        dbus_we_q, dbus_we_d;
    logic [31:0] dbus_addr_q, dbus_addr_d;
    logic [31:0] dbus_wdata_q, dbus_wdata_d;
    logic [3:0]  dbus_be_q, dbus_be_d;

    logic [2:0]  funct3;
    logic        is_load, is_store, is_mem, misaligned;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    always_comb begin
        funct3     = INST_i[14:12];
        is_load    = (INST_i[6:0] == OP_LOAD) &&
                     (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        is_store   = (INST_i[6:0] == OP_STORE) &&
                     (funct3 inside {3'b000, 3'b001, 3'b010});
        is_mem     = is_load || is_store;
        misaligned = ((funct3[1:0] == 2'b01) && mem_addr_i[0]) ||
                     ((funct3[1:0] == 2'b10) && (mem_addr_i[1:0] != 2'b00));
    end

    // Loads always read the whole word; lane selection happens on the way back.
    always_comb begin
        st_be   = 4'b1111;
        st_data = 32'd0;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    st_be   = 4'b0001 << mem_addr_i[1:0];
                    st_data = {4{mem_sdata_i[7:0]}};
                end
                2'b01: begin
                    st_be   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                    st_data = {2{mem_sdata_i[15:0]}};
                end
                default: st_data = mem_sdata_i;
            endcase
        end
    end

    always_comb begin
        ld_byte = rdata_q[8*mem_addr_i[1:0] +: 8];
        ld_half = mem_addr_i[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (funct3)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = rdata_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        dbus_req_d   = dbus_req_q;
        dbus_we_d    = dbus_we_q;
        dbus_addr_d  = dbus_addr_q;
        dbus_wdata_d = dbus_wdata_q;
        dbus_be_d    = dbus_be_q;
        case (state_q)
            IDLE: begin
                if (is_mem && !misaligned) begin
                    state_d      = REQ;
                    cnt_d        = 8'd0;
                    dbus_req_d   = 1'b1;
                    dbus_we_d    = is_store;
                    dbus_addr_d  = {mem_addr_i[31:2], 2'b00};
                    dbus_wdata_d = st_data;
                    dbus_be_d    = st_be;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (dbus_ack_i) begin
                    rdata_d    = dbus_rdata_i;
                    dbus_req_d = 1'b0;
                    state_d    = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d      = 1'b1;
                    dbus_req_d = 1'b0;
                    state_d    = DONE;
                end
            end
            default: begin
                // DONE never lingers, so a held instruction is never re-issued.
                state_d = IDLE;
                cnt_d   = 8'd0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge arst) begin
        if (arst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= 32'd0;
            dbus_wdata_q <= 32'd0;
            dbus_be_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            dbus_req_q   <= dbus_req_d;
            dbus_we_q    <= dbus_we_d;
            dbus_addr_q  <= dbus_addr_d;
            dbus_wdata_q <= dbus_wdata_d;
            dbus_be_q    <= dbus_be_d;
        end
    end

    // Everything is gated by arst so the stage goes quiet the instant reset rises.
    always_comb begin
        dbus_req_o   = 1'b0;
        dbus_we_o    = 1'b0;
        dbus_addr_o  = 32'd0;
        dbus_wdata_o = 32'd0;
        dbus_be_o    = 4'd0;
        hold_req_o   = 1'b0;
        misalign_o   = 1'b0;
        bus_err_o    = 1'b0;
        INST_o       = 32'd0;
        mem_rena_o   = 1'b0;
        mem_rdata_o  = 32'd0;
        mem_raddr_o  = 32'd0;
        reg_wena_o   = 1'b0;
        reg_wdata_o  = 32'd0;
        reg_waddr_o  = 5'd0;
        mem_wena_o   = 1'b0;
        mem_waddr_o  = 32'd0;
        mem_wdata_o  = 32'd0;
        if (!arst) begin
            dbus_req_o   = dbus_req_q;
            dbus_we_o    = dbus_we_q;
            dbus_addr_o  = dbus_addr_q;
            dbus_wdata_o = dbus_wdata_q;
            dbus_be_o    = dbus_be_q;
            INST_o       = INST_i;
            reg_waddr_o  = reg_waddr_i;
            case (state_q)
                IDLE: begin
                    if (!is_mem) begin
                        reg_wena_o  = reg_wena_i;
                        reg_wdata_o = reg_wdata_i;
                    end else if (misaligned) begin
                        misalign_o = 1'b1;
                    end else begin
                        hold_req_o = 1'b1;
                    end
                end
                REQ: hold_req_o = 1'b1;
                default: begin
                    if (err_q) begin
                        bus_err_o = 1'b1;
                    end else if (is_load) begin
                        mem_rena_o  = 1'b1;
                        mem_rdata_o = rdata_q;
                        mem_raddr_o = mem_addr_i;
                        reg_wdata_o = ld_val;
                        reg_wena_o  = reg_wena_i;
                    end else if (is_store) begin
                        mem_wena_o  = 1'b1;
                        mem_waddr_o = mem_addr_i;
                        mem_wdata_o = dbus_wdata_q;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT=4): pass-through, load, delayed store, misalign, timeout, reset abort.
module tb_mem_stage;
    logic        clk_100MHz = 1'b0;
    logic        arst;
    logic [31:0] INST_i;
    logic        reg_wena_i;
    logic [31:0] reg_wdata_i;
    logic [4:0]  reg_waddr_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_sdata_i;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o;
    logic [3:0]  dbus_be_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;
    logic        hold_req_o, misalign_o, bus_err_o;
    logic [31:0] INST_o;
    logic        mem_rena_o;
    logic [31:0] mem_rdata_o, mem_raddr_o;
    logic        reg_wena_o;
    logic [31:0] reg_wdata_o;
    logic [4:0]  reg_waddr_o;
    logic        mem_wena_o;
    logic [31:0] mem_waddr_o, mem_wdata_o;

    int n_run  = 0;
    int n_fail = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk_100MHz(clk_100MHz), .arst(arst),
        .INST_i(INST_i), .reg_wena_i(reg_wena_i), .reg_wdata_i(reg_wdata_i),
        .reg_waddr_i(reg_waddr_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o), .dbus_ack_i(dbus_ack_i),
        .dbus_rdata_i(dbus_rdata_i), .hold_req_o(hold_req_o), .misalign_o(misalign_o),
        .bus_err_o(bus_err_o), .INST_o(INST_o), .mem_rena_o(mem_rena_o),
        .mem_rdata_o(mem_rdata_o), .mem_raddr_o(mem_raddr_o), .reg_wena_o(reg_wena_o),
        .reg_wdata_o(reg_wdata_o), .reg_waddr_o(reg_waddr_o), .mem_wena_o(mem_wena_o),
        .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        return {17'd0, f3, 5'd3, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 ns after the rising edge; checks follow 1 ns later.
    task automatic step();
        @(posedge clk_100MHz);
        #2;
    endtask

    initial begin
        arst = 1'b1; INST_i = NOP; reg_wena_i = 1'b1; reg_wdata_i = 32'h5555;
        reg_waddr_i = 5'd7; mem_addr_i = 32'h0; mem_sdata_i = 32'h0;
        dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;
        #13;
        chk("rst_inst_o", INST_o, 32'h0);
        chk("rst_wdata", reg_wdata_o, 32'h0);
        chk("rst_wena", {31'd0, reg_wena_o}, 32'd0);
        chk("rst_req", {31'd0, dbus_req_o}, 32'd0);
        chk("rst_be", {28'd0, dbus_be_o}, 32'd0);
        arst = 1'b0;
        step();

        // ALU pass-through
        reg_wdata_i = 32'h1234; #1;
        chk("alu_wdata", reg_wdata_o, 32'h1234);
        chk("alu_wena", {31'd0, reg_wena_o}, 32'd1);
        chk("alu_hold", {31'd0, hold_req_o}, 32'd0);
        chk("alu_inst", INST_o, NOP);
        chk("alu_waddr", {27'd0, reg_waddr_o}, 32'd7);
        step(); #1;
        chk("alu_noreq", {31'd0, dbus_req_o}, 32'd0);

        // LB 0x103, ack in first REQ cycle
        INST_i = mk(7'b0000011, 3'b000); mem_addr_i = 32'h103; #1;
        chk("lb_t0_hold", {31'd0, hold_req_o}, 32'd1);
        chk("lb_t0_wena", {31'd0, reg_wena_o}, 32'd0);
        step(); #1;
        chk("lb_t1_req", {31'd0, dbus_req_o}, 32'd1);
        chk("lb_t1_addr", dbus_addr_o, 32'h100);
        chk("lb_t1_be", {28'd0, dbus_be_o}, 32'hF);
        chk("lb_t1_we", {31'd0, dbus_we_o}, 32'd0);
        chk("lb_t1_hold", {31'd0, hold_req_o}, 32'd1);
        dbus_ack_i = 1'b1; dbus_rdata_i = 32'h80FF_0000;
        step(); dbus_ack_i = 1'b0; #1;
        chk("lb_done_hold", {31'd0, hold_req_o}, 32'd0);
        chk("lb_done_req", {31'd0, dbus_req_o}, 32'd0);
        chk("lb_done_wdata", reg_wdata_o, 32'hFFFF_FF80);
        chk("lb_done_rdata", mem_rdata_o, 32'h80FF_0000);
        chk("lb_done_rena", {31'd0, mem_rena_o}, 32'd1);
        chk("lb_done_raddr", mem_raddr_o, 32'h103);
        chk("lb_done_wena", {31'd0, reg_wena_o}, 32'd1);
        INST_i = NOP;
        step(); #1;
        chk("lb_idle_rena", {31'd0, mem_rena_o}, 32'd0);

        // SH 0x202, ack three cycles after req rises
        INST_i = mk(7'b0100011, 3'b001); mem_addr_i = 32'h202; mem_sdata_i = 32'hABCD_1234;
        step(); #1;
        chk("sh_t1_be", {28'd0, dbus_be_o}, 32'hC);
        chk("sh_t1_wdata", dbus_wdata_o, 32'h1234_1234);
        chk("sh_t1_we", {31'd0, dbus_we_o}, 32'd1);
        chk("sh_t1_addr", dbus_addr_o, 32'h200);
        step(); #1;
        chk("sh_t2_hold", {31'd0, hold_req_o}, 32'd1);
        step(); #1;
        chk("sh_t3_req", {31'd0, dbus_req_o}, 32'd1);
        chk("sh_t3_wena", {31'd0, mem_wena_o}, 32'd0);
        step(); dbus_ack_i = 1'b1; #1;
        chk("sh_t4_hold", {31'd0, hold_req_o}, 32'd1);
        step(); dbus_ack_i = 1'b0; #1;
        chk("sh_done_wena", {31'd0, mem_wena_o}, 32'd1);
        chk("sh_done_waddr", mem_waddr_o, 32'h202);
        chk("sh_done_wdata", mem_wdata_o, 32'h1234_1234);
        chk("sh_done_regwena", {31'd0, reg_wena_o}, 32'd0);
        chk("sh_done_hold", {31'd0, hold_req_o}, 32'd0);
        INST_i = NOP;
        step();

        // LW 0x301 misaligned
        INST_i = mk(7'b0000011, 3'b010); mem_addr_i = 32'h301; #1;
        chk("lw_mis_flag", {31'd0, misalign_o}, 32'd1);
        chk("lw_mis_hold", {31'd0, hold_req_o}, 32'd0);
        chk("lw_mis_wena", {31'd0, reg_wena_o}, 32'd0);
        step(); #1;
        chk("lw_mis_noreq", {31'd0, dbus_req_o}, 32'd0);
        INST_i = NOP;
        step();

        // LHU 0x400, never acked: 4 REQ cycles then error DONE
        INST_i = mk(7'b0000011, 3'b101); mem_addr_i = 32'h400;
        for (int i = 1; i <= 4; i++) begin
            step(); #1;
            chk($sformatf("to_req_c%0d", i), {31'd0, dbus_req_o}, 32'd1);
            chk($sformatf("to_err_c%0d", i), {31'd0, bus_err_o}, 32'd0);
        end
        step(); #1;
        chk("to_done_err", {31'd0, bus_err_o}, 32'd1);
        chk("to_done_wena", {31'd0, reg_wena_o}, 32'd0);
        chk("to_done_rena", {31'd0, mem_rena_o}, 32'd0);
        chk("to_done_req", {31'd0, dbus_req_o}, 32'd0);
        chk("to_done_hold", {31'd0, hold_req_o}, 32'd0);
        INST_i = NOP;
        step(); #1;
        chk("to_idle_err", {31'd0, bus_err_o}, 32'd0);

        // Reset in the middle of a LW, then a late ack
        INST_i = mk(7'b0000011, 3'b010); mem_addr_i = 32'h500;
        step(); #1;
        chk("ra_req_before", {31'd0, dbus_req_o}, 32'd1);
        arst = 1'b1; #1;
        chk("ra_req_rst", {31'd0, dbus_req_o}, 32'd0);
        chk("ra_hold_rst", {31'd0, hold_req_o}, 32'd0);
        chk("ra_inst_rst", INST_o, 32'h0);
        INST_i = NOP; dbus_ack_i = 1'b1; dbus_rdata_i = 32'h1111_2222;
        step(); arst = 1'b0;
        step(); dbus_ack_i = 1'b0; #1;
        chk("ra_ack_req", {31'd0, dbus_req_o}, 32'd0);
        chk("ra_ack_rena", {31'd0, mem_rena_o}, 32'd0);
        chk("ra_ack_wdata", reg_wdata_o, 32'h1234);
        INST_i = mk(7'b0000011, 3'b010); mem_addr_i = 32'h504;
        step(); #1;
        chk("ra_lw_addr", dbus_addr_o, 32'h504);
        dbus_ack_i = 1'b1; dbus_rdata_i = 32'hDEAD_BEEF;
        step(); dbus_ack_i = 1'b0; #1;
        chk("ra_lw_wdata", reg_wdata_o, 32'hDEAD_BEEF);
        chk("ra_lw_rena", {31'd0, mem_rena_o}, 32'd1);
        chk("ra_lw_wena", {31'd0, reg_wena_o}, 32'd1);
        INST_i = NOP;
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
